big_core_alu_seq: RTL

- Multi-cycle sequencer driving the big_core R-type ALU.
- Accepts one 32-bit R-type instruction through a valid/ready handshake.
- Reads rs1 and rs2 one at a time through a single register-file read port.
- Presents operands and function fields to the combinational ALU, then writes the result back to rd. Sits between the instruction source and the shared ALU and register file.

---
 rtl/big_core_alu_seq.sv | 240 ++++++++++++++++++++++++
 1 files changed

// File: rtl/big_core_alu_seq.sv
// -----------------------------------------------------------------------------
// big_core_alu_seq
//
// Multi-cycle sequencer for the big_core R-type ALU. It takes one instruction
// over a valid/ready handshake and reads rs1 then rs2 through a single
// register-file read port. It then presents the operands and function fields
// to the external combinational ALU and writes the captured result back to rd.
//
//   IDLE -> RD_RS1 -> RD_RS2 -> EXEC -> WB -> IDLE   (one cycle per busy state)
//
// Ports
//   Clock, RstN            clock (rising edge), synchronous active-low reset
//   InstValid/Inst/InstReady  instruction handshake (accepted in IDLE only)
//   RfRdAddr/RfRdData      register-file read port (data combinational)
//   AluOp1/AluOp2/AluFunct3/AluFunct7  operands and fields to the ALU
//   AluResult              ALU result (combinational from the Alu* outputs)
//   RfWrEn/RfWrAddr/RfWrData  register-file write port (asserted in WB)
//   RetireValid/RetireCnt  retire pulse and wrapping retired-instruction count
//   Busy                   high whenever the sequencer is not IDLE
//   IllegalInst            only with ALU_SEQ_ILLEGAL_CHK_EN: pulses with
//                          RetireValid when the retiring word was not a legal
//                          R-type ALU op (its write is suppressed)
//
// Build option: define ALU_SEQ_ILLEGAL_CHK_EN to add legality checking and the
// IllegalInst output.
//
// All outputs come straight from flops. Their next values are computed from
// the next state in the combinational block, so they line up with the state.
// -----------------------------------------------------------------------------
module big_core_alu_seq #(
   parameter int CNT_W = 16,
   parameter int XLEN  = 32
) (
   input  logic             Clock,
   input  logic             RstN,
   input  logic             InstValid,
   input  logic [31:0]      Inst,
   output logic             InstReady,
   output logic [4:0]       RfRdAddr,
   input  logic [XLEN-1:0]  RfRdData,
   output logic [XLEN-1:0]  AluOp1,
   output logic [XLEN-1:0]  AluOp2,
   output logic [2:0]       AluFunct3,
   output logic [6:0]       AluFunct7,
   input  logic [XLEN-1:0]  AluResult,
   output logic             RfWrEn,
   output logic [4:0]       RfWrAddr,
   output logic [XLEN-1:0]  RfWrData,
   output logic             RetireValid,
   output logic [CNT_W-1:0] RetireCnt,
`ifdef ALU_SEQ_ILLEGAL_CHK_EN
   output logic             IllegalInst,
`endif
   output logic             Busy
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      RD_RS1 = 3'd1,
      RD_RS2 = 3'd2,
      EXEC   = 3'd3,
      WB     = 3'd4
   } state_t;

   typedef struct packed {
      logic [6:0] funct7;
      logic [4:0] rs2;
      logic [4:0] rs1;
      logic [2:0] funct3;
      logic [4:0] rd;
      logic [6:0] opcode;
   } rtype_t;

   state_t            state_q, state_d;
   rtype_t            inst_q, inst_d;
   logic [XLEN-1:0]   op1_q, op1_d;
   logic [XLEN-1:0]   op2_q, op2_d;
   logic [XLEN-1:0]   res_q, res_d;
   logic [4:0]        rd_addr_q, rd_addr_d;
   logic              inst_ready_q, inst_ready_d;
   logic              busy_q, busy_d;
   logic              wr_en_q, wr_en_d;
   logic              retire_q, retire_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              accept;
   logic              wr_allowed;
   rtype_t            inst_in;

   assign inst_in = rtype_t'(Inst);
   // State is IDLE exactly when InstReady is high, so the handshake is simply
   // InstValid qualified by the registered ready.
   assign accept  = InstValid && inst_ready_q;

`ifdef ALU_SEQ_ILLEGAL_CHK_EN
   logic illegal_q, illegal_d;
   logic illegal_out_q, illegal_out_d;

   // Only ADD/SUB/SLL/SLT/SLTU/XOR/SRL/SRA/OR/AND under the OP opcode are legal;
   // the alternate funct7 is only meaningful for SUB and SRA.
   function automatic logic is_illegal(input rtype_t i);
      logic bad;
      bad = 1'b0;
      if (i.opcode != 7'b0110011)
         bad = 1'b1;
      else if (i.funct7 != 7'b0000000 && i.funct7 != 7'b0100000)
         bad = 1'b1;
      else if (i.funct7 == 7'b0100000 && i.funct3 != 3'b000 && i.funct3 != 3'b101)
         bad = 1'b1;
      return bad;
   endfunction

   assign wr_allowed = !illegal_q;
`else
   // Without the checker every accepted word executes as R-type, so the opcode
   // field is never looked at.
   logic unused_opcode;
   assign unused_opcode = ^inst_in.opcode;
   assign wr_allowed    = 1'b1;
`endif

   // rs1 is read straight from Inst on the accepting edge and the latched
   // opcode is only used at accept time, so those latched bits have no reader.
   logic unused_inst_bits;
   assign unused_inst_bits = ^{inst_q.rs1, inst_q.opcode};

   always_comb begin
      state_d      = state_q;
      inst_d       = inst_q;
      op1_d        = op1_q;
      op2_d        = op2_q;
      res_d        = res_q;
      rd_addr_d    = 5'd0;
      inst_ready_d = 1'b0;
      busy_d       = 1'b0;
      wr_en_d      = 1'b0;
      retire_d     = 1'b0;
      cnt_d        = cnt_q;

      case (state_q)
         IDLE:    if (accept) state_d = RD_RS1;
         RD_RS1:  state_d = RD_RS2;
         RD_RS2:  state_d = EXEC;
         EXEC:    state_d = WB;
         WB:      state_d = IDLE;
         default: state_d = IDLE;
      endcase

      if (accept)
         inst_d = inst_in;

      // Operand/result capture happens at the edge that ends the owning state.
      if (state_q == RD_RS1) op1_d = RfRdData;
      if (state_q == RD_RS2) op2_d = RfRdData;
      if (state_q == EXEC)   res_d = AluResult;

      // Read address is registered, so it is chosen from the state being
      // entered. RD_RS1 is only ever entered on accept, so rs1 comes from Inst.
      case (state_d)
         RD_RS1:  rd_addr_d = inst_in.rs1;
         RD_RS2:  rd_addr_d = inst_q.rs2;
         default: rd_addr_d = 5'd0;
      endcase

      inst_ready_d = (state_d == IDLE);
      busy_d       = (state_d != IDLE);

      if (state_d == WB) begin
         retire_d = 1'b1;
         // x0 writes are dropped but still retire.
         wr_en_d  = (inst_q.rd != 5'd0) && wr_allowed;
         cnt_d    = cnt_q + CNT_W'(1);
      end
   end

`ifdef ALU_SEQ_ILLEGAL_CHK_EN
   always_comb begin
      illegal_d     = illegal_q;
      illegal_out_d = 1'b0;
      if (accept)
         illegal_d = is_illegal(inst_in);
      if (state_d == WB)
         illegal_out_d = illegal_q;
   end
`endif

   always_ff @(posedge Clock) begin
      if (!RstN) begin
         state_q      <= IDLE;
         inst_q       <= '0;
         op1_q        <= '0;
         op2_q        <= '0;
         res_q        <= '0;
         rd_addr_q    <= '0;
         inst_ready_q <= 1'b1;
         busy_q       <= 1'b0;
         wr_en_q      <= 1'b0;
         retire_q     <= 1'b0;
         cnt_q        <= '0;
`ifdef ALU_SEQ_ILLEGAL_CHK_EN
         illegal_q     <= 1'b0;
         illegal_out_q <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         inst_q       <= inst_d;
         op1_q        <= op1_d;
         op2_q        <= op2_d;
         res_q        <= res_d;
         rd_addr_q    <= rd_addr_d;
         inst_ready_q <= inst_ready_d;
         busy_q       <= busy_d;
         wr_en_q      <= wr_en_d;
         retire_q     <= retire_d;
         cnt_q        <= cnt_d;
`ifdef ALU_SEQ_ILLEGAL_CHK_EN
         illegal_q     <= illegal_d;
         illegal_out_q <= illegal_out_d;
`endif
      end
   end

   // ALU-facing fields hold whatever was last latched; they are only
   // meaningful during EXEC.
   assign InstReady   = inst_ready_q;
   assign RfRdAddr    = rd_addr_q;
   assign AluOp1      = op1_q;
   assign AluOp2      = op2_q;
   assign AluFunct3   = inst_q.funct3;
   assign AluFunct7   = inst_q.funct7;
   assign RfWrEn      = wr_en_q;
   assign RfWrAddr    = inst_q.rd;
   assign RfWrData    = res_q;
   assign RetireValid = retire_q;
   assign RetireCnt   = cnt_q;
   assign Busy        = busy_q;
`ifdef ALU_SEQ_ILLEGAL_CHK_EN
   assign IllegalInst = illegal_out_q;
`endif

endmodule
